// File: rtl/multi_port_branch_resolve.sv
// rtl/multi_port_branch_resolve.sv - multi-port branch resolution with registered redirect and predictor-update queue
//
// Resolves NrPorts control-flow instructions per cycle (port 0 oldest). The oldest
// mispredict or misaligned-target exception is reported one cycle after issue, and
// every unsquashed, non-excepting resolution is queued in order for predictor training.
//
// Optional feature macro: BRU_PERF_COUNTERS_EN (adds perf_resolved_o / perf_mispredict_o).
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   flush_i                        suppress next-cycle registered outputs
//   valid_i, is_jalr_i, is_branch_i, is_compressed_i, comp_res_i   per-port controls
//   pc_i, operand_a_i, imm_i, pred_addr_i (VLEN each), pred_cf_i (3 each)  per-port data
//   ready_o                        room for a full NrPorts group in the queue
//   result_valid_o, result_o       registered link value (next pc) per port
//   mispredict_o, redirect_pc_o    registered redirect pulse and target
//   ex_valid_o, ex_tval_o          registered misaligned-target exception, sign-extended pc
//   upd_*                          predictor-update queue head, valid/ready handshake
module multi_port_branch_resolve #(
  parameter int unsigned NrPorts    = 2,
  parameter int unsigned VLEN       = 39,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RVC        = 1,
  parameter int unsigned QueueDepth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NrPorts-1:0]      valid_i,
  input  logic [NrPorts-1:0]      is_jalr_i,
  input  logic [NrPorts-1:0]      is_branch_i,
  input  logic [NrPorts*VLEN-1:0] pc_i,
  input  logic [NrPorts*VLEN-1:0] operand_a_i,
  input  logic [NrPorts*VLEN-1:0] imm_i,
  input  logic [NrPorts-1:0]      is_compressed_i,
  input  logic [NrPorts-1:0]      comp_res_i,
  input  logic [NrPorts*3-1:0]    pred_cf_i,
  input  logic [NrPorts*VLEN-1:0] pred_addr_i,
  output logic                    ready_o,
  output logic [NrPorts-1:0]      result_valid_o,
  output logic [NrPorts*VLEN-1:0] result_o,
  output logic                    mispredict_o,
  output logic [VLEN-1:0]         redirect_pc_o,
  output logic                    ex_valid_o,
  output logic [XLEN-1:0]         ex_tval_o,
  output logic                    upd_valid_o,
  input  logic                    upd_ready_i,
  output logic [VLEN-1:0]         upd_pc_o,
  output logic [VLEN-1:0]         upd_target_o,
  output logic                    upd_taken_o,
  output logic                    upd_mispredict_o,
`ifdef BRU_PERF_COUNTERS_EN
  output logic [31:0]             perf_resolved_o,
  output logic [31:0]             perf_mispredict_o,
`endif
  output logic [2:0]              upd_cf_o
);

  localparam logic [2:0] CF_NO  = 3'd0;
  localparam logic [2:0] CF_BR  = 3'd1;
  localparam logic [2:0] CF_JMP = 3'd2;
  localparam logic [2:0] CF_JR  = 3'd3;
  localparam logic [2:0] CF_RET = 3'd4;
  localparam int unsigned AW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CW = $clog2(QueueDepth + 1);

  logic [NrPorts-1:0][VLEN-1:0] w_pc, w_opa, w_imm, w_paddr;
  logic [NrPorts-1:0][VLEN-1:0] w_next_pc, w_tgt, w_resolved;
  logic [NrPorts-1:0][2:0]      w_pcf, w_cf;
  logic [NrPorts-1:0]           w_go, w_taken, w_misp, w_exc, w_enq;
  logic [AW-1:0]                w_idx [NrPorts];
  logic [CW-1:0]                w_enq_n;
  logic                         w_seen, w_evt_misp, w_evt_exc, w_deq, w_nonempty;
  logic [VLEN-1:0]              w_evt_target, w_evt_pc;

  logic [NrPorts-1:0]           r_result_valid;
  logic [NrPorts-1:0][VLEN-1:0] r_result;
  logic                         r_misp, r_ex_valid;
  logic [VLEN-1:0]              r_redirect;
  logic [XLEN-1:0]              r_ex_tval;
  logic [AW-1:0]                r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic [VLEN-1:0]              r_q_pc     [QueueDepth];
  logic [VLEN-1:0]              r_q_target [QueueDepth];
  logic                         r_q_taken  [QueueDepth];
  logic                         r_q_misp   [QueueDepth];
  logic [2:0]                   r_q_cf     [QueueDepth];

  assign w_pc    = pc_i;
  assign w_opa   = operand_a_i;
  assign w_imm   = imm_i;
  assign w_paddr = pred_addr_i;
  assign w_pcf   = pred_cf_i;

  // Derived only from the occupancy register so issue never waits on upd_ready_i.
  assign ready_o = (CW'(QueueDepth) - r_count) >= CW'(NrPorts);
  // An illegal group presented while full is dropped rather than overwriting entries.
  assign w_go    = valid_i & {NrPorts{ready_o}};

  always_comb begin
    w_seen       = 1'b0;
    w_evt_misp   = 1'b0;
    w_evt_exc    = 1'b0;
    w_evt_target = '0;
    w_evt_pc     = '0;
    w_enq        = '0;
    w_enq_n      = '0;
    for (int p = 0; p < NrPorts; p++) begin
      w_next_pc[p] = w_pc[p] + (is_compressed_i[p] ? VLEN'(2) : VLEN'(4));
      w_tgt[p]     = (is_jalr_i[p] ? w_opa[p] : w_pc[p]) + w_imm[p];
      if (is_jalr_i[p]) w_tgt[p][0] = 1'b0;
      w_taken[p] = 1'b1;
      w_misp[p]  = 1'b0;
      w_cf[p]    = CF_JMP;
      if (is_branch_i[p]) begin
        w_taken[p] = comp_res_i[p];
        w_cf[p]    = CF_BR;
        w_misp[p]  = comp_res_i[p] != (w_pcf[p] == CF_BR);
      end else if (is_jalr_i[p]) begin
        w_misp[p] = (w_pcf[p] == CF_NO) || (w_tgt[p] != w_paddr[p]);
        w_cf[p]   = (w_pcf[p] == CF_RET) ? CF_RET : CF_JR;
      end
      w_resolved[p] = w_taken[p] ? w_tgt[p] : w_next_pc[p];
      w_exc[p]      = w_taken[p] && (w_tgt[p][0] || ((RVC == 0) && w_tgt[p][1]));
      // Slot = write pointer plus the number of earlier ports enqueued this cycle.
      w_idx[p] = AW'((32'(r_wr_ptr) + 32'(w_enq_n)) & (QueueDepth - 1));
      if (w_go[p] && !w_seen) begin
        if (!w_exc[p]) begin
          w_enq[p] = 1'b1;
          w_enq_n  = w_enq_n + CW'(1);
        end
        // First event port squashes every younger port in the group.
        if (w_exc[p] || w_misp[p]) begin
          w_seen       = 1'b1;
          w_evt_exc    = w_exc[p];
          w_evt_misp   = !w_exc[p];
          w_evt_target = w_resolved[p];
          w_evt_pc     = w_pc[p];
        end
      end
    end
  end

  assign w_nonempty = r_count != '0;
  assign w_deq      = w_nonempty && upd_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result_valid <= '0;
      r_result       <= '0;
      r_misp         <= 1'b0;
      r_redirect     <= '0;
      r_ex_valid     <= 1'b0;
      r_ex_tval      <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_result_valid <= flush_i ? '0 : w_enq;
      for (int p = 0; p < NrPorts; p++)
        r_result[p] <= (w_enq[p] && !flush_i) ? w_next_pc[p] : '0;
      r_misp     <= w_evt_misp && !flush_i;
      r_redirect <= (w_evt_misp && !flush_i) ? w_evt_target : '0;
      r_ex_valid <= w_evt_exc && !flush_i;
      r_ex_tval  <= (w_evt_exc && !flush_i) ?
                    {{(XLEN-VLEN){w_evt_pc[VLEN-1]}}, w_evt_pc} : '0;
      r_wr_ptr   <= AW'((32'(r_wr_ptr) + 32'(w_enq_n)) & (QueueDepth - 1));
      if (w_deq) r_rd_ptr <= AW'((32'(r_rd_ptr) + 32'd1) & (QueueDepth - 1));
      r_count    <= r_count + w_enq_n - CW'(w_deq);
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrPorts; p++) begin
      if (w_enq[p]) begin
        r_q_pc[w_idx[p]]     <= w_pc[p];
        r_q_target[w_idx[p]] <= w_resolved[p];
        r_q_taken[w_idx[p]]  <= w_taken[p];
        r_q_misp[w_idx[p]]   <= w_misp[p];
        r_q_cf[w_idx[p]]     <= w_cf[p];
      end
    end
  end

  assign result_valid_o   = r_result_valid;
  assign result_o         = r_result;
  assign mispredict_o     = r_misp;
  assign redirect_pc_o    = r_redirect;
  assign ex_valid_o       = r_ex_valid;
  assign ex_tval_o        = r_ex_tval;
  assign upd_valid_o      = w_nonempty;
  assign upd_pc_o         = w_nonempty ? r_q_pc[r_rd_ptr]     : '0;
  assign upd_target_o     = w_nonempty ? r_q_target[r_rd_ptr] : '0;
  assign upd_taken_o      = w_nonempty && r_q_taken[r_rd_ptr];
  assign upd_mispredict_o = w_nonempty && r_q_misp[r_rd_ptr];
  assign upd_cf_o         = w_nonempty ? r_q_cf[r_rd_ptr] : 3'd0;

`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] r_perf_resolved, r_perf_misp;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_resolved <= '0;
      r_perf_misp     <= '0;
    end else begin
      r_perf_resolved <= r_perf_resolved + 32'(w_enq_n);
      r_perf_misp     <= r_perf_misp + 32'(w_evt_misp);
    end
  end
  assign perf_resolved_o   = r_perf_resolved;
  assign perf_mispredict_o = r_perf_misp;
`endif

  a_no_issue_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|valid_i) |-> ready_o);

endmodule

// File: tb/tb_multi_port_branch_resolve.sv
// tb/tb_multi_port_branch_resolve.sv - scoreboard bench for multi_port_branch_resolve
module tb_multi_port_branch_resolve;
  localparam int NP = 2;
  localparam int VL = 39;
  localparam int XL = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic upd_ready = 1'b0;
  logic [NP-1:0] valid = '0, valid_r0 = '0, is_jalr = '0, is_branch = '0;
  logic [NP-1:0] is_comp = '0, comp_res = '0;
  logic [NP*VL-1:0] pc = '0, opa = '0, imm = '0, paddr = '0;
  logic [NP*3-1:0] pcf = '0;

  logic ready, misp, exv, updv, upd_taken, upd_misp;
  logic [NP-1:0] rv;
  logic [NP*VL-1:0] res;
  logic [VL-1:0] rpc, upd_pc, upd_tgt;
  logic [XL-1:0] tval;
  logic [2:0] upd_cf;

  logic r0_ready, r0_misp, r0_exv, r0_updv, r0_upd_taken, r0_upd_misp;
  logic [NP-1:0] r0_rv;
  logic [NP*VL-1:0] r0_res;
  logic [VL-1:0] r0_rpc, r0_upd_pc, r0_upd_tgt;
  logic [XL-1:0] r0_tval;
  logic [2:0] r0_upd_cf;
`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] perf_res, perf_mis, r0_perf_res, r0_perf_mis;
`endif

  always #5 clk = ~clk;

  multi_port_branch_resolve #(.NrPorts(NP), .VLEN(VL), .XLEN(XL), .RVC(1), .QueueDepth(4)) dut (
`ifdef BRU_PERF_COUNTERS_EN
    .perf_resolved_o(perf_res), .perf_mispredict_o(perf_mis),
`endif
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
    .is_jalr_i(is_jalr), .is_branch_i(is_branch), .pc_i(pc), .operand_a_i(opa),
    .imm_i(imm), .is_compressed_i(is_comp), .comp_res_i(comp_res), .pred_cf_i(pcf),
    .pred_addr_i(paddr), .ready_o(ready), .result_valid_o(rv), .result_o(res),
    .mispredict_o(misp), .redirect_pc_o(rpc), .ex_valid_o(exv), .ex_tval_o(tval),
    .upd_valid_o(updv), .upd_ready_i(upd_ready), .upd_pc_o(upd_pc),
    .upd_target_o(upd_tgt), .upd_taken_o(upd_taken), .upd_mispredict_o(upd_misp),
    .upd_cf_o(upd_cf));

  multi_port_branch_resolve #(.NrPorts(NP), .VLEN(VL), .XLEN(XL), .RVC(0), .QueueDepth(4)) dut_r0 (
`ifdef BRU_PERF_COUNTERS_EN
    .perf_resolved_o(r0_perf_res), .perf_mispredict_o(r0_perf_mis),
`endif
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_r0),
    .is_jalr_i(is_jalr), .is_branch_i(is_branch), .pc_i(pc), .operand_a_i(opa),
    .imm_i(imm), .is_compressed_i(is_comp), .comp_res_i(comp_res), .pred_cf_i(pcf),
    .pred_addr_i(paddr), .ready_o(r0_ready), .result_valid_o(r0_rv), .result_o(r0_res),
    .mispredict_o(r0_misp), .redirect_pc_o(r0_rpc), .ex_valid_o(r0_exv), .ex_tval_o(r0_tval),
    .upd_valid_o(r0_updv), .upd_ready_i(1'b1), .upd_pc_o(r0_upd_pc),
    .upd_target_o(r0_upd_tgt), .upd_taken_o(r0_upd_taken), .upd_mispredict_o(r0_upd_misp),
    .upd_cf_o(r0_upd_cf));

  typedef struct {
    logic [NP-1:0] rv;
    logic [VL-1:0] r0, r1, rpc;
    logic misp, exv;
    logic [XL-1:0] tval;
  } res_t;
  typedef struct {
    logic [VL-1:0] pc, tgt;
    logic taken, misp;
    logic [2:0] cf;
  } upd_t;

  res_t res_q[$];
  upd_t upd_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic exp_res(input logic [NP-1:0] e_rv, input logic [VL-1:0] e_r0, e_r1,
                         input logic e_m, input logic [VL-1:0] e_rpc,
                         input logic e_ex, input logic [XL-1:0] e_tv);
    res_t e;
    e.rv = e_rv; e.r0 = e_r0; e.r1 = e_r1; e.misp = e_m; e.rpc = e_rpc;
    e.exv = e_ex; e.tval = e_tv;
    res_q.push_back(e);
  endtask

  task automatic exp_upd(input logic [VL-1:0] e_pc, e_tgt, input logic e_tk, e_m,
                         input logic [2:0] e_cf);
    upd_t e;
    e.pc = e_pc; e.tgt = e_tgt; e.taken = e_tk; e.misp = e_m; e.cf = e_cf;
    upd_q.push_back(e);
  endtask

  task automatic clear_ports();
    valid = '0; valid_r0 = '0; flush = 1'b0; is_jalr = '0; is_branch = '0;
    is_comp = '0; comp_res = '0; pc = '0; opa = '0; imm = '0; paddr = '0; pcf = '0;
  endtask

  // kind: 0 JAL, 1 branch, 2 JALR
  task automatic set_port(input int p, input int kind, input logic [VL-1:0] a_pc, a_opa, a_imm,
                          input logic a_comp, a_cres, input logic [2:0] a_pcf,
                          input logic [VL-1:0] a_paddr);
    valid[p] = 1'b1;
    is_branch[p] = (kind == 1);
    is_jalr[p] = (kind == 2);
    pc[p*VL +: VL] = a_pc;
    opa[p*VL +: VL] = a_opa;
    imm[p*VL +: VL] = a_imm;
    is_comp[p] = a_comp;
    comp_res[p] = a_cres;
    pcf[p*3 +: 3] = a_pcf;
    paddr[p*VL +: VL] = a_paddr;
  endtask

  task automatic next_slot();
    @(posedge clk); #1;
    clear_ports();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && upd_q.size() != 0; i++) @(posedge clk);
    chk("upd_drain_left", 64'(upd_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (|rv || misp || exv)) begin
      if (res_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got rv=%b misp=%b ex=%b want no output", rv, misp, exv);
      end else begin
        res_t e;
        e = res_q.pop_front();
        chk("result_valid", 64'(rv), 64'(e.rv));
        chk("result0", 64'(res[VL-1:0]), 64'(e.r0));
        chk("result1", 64'(res[2*VL-1:VL]), 64'(e.r1));
        chk("mispredict", 64'(misp), 64'(e.misp));
        chk("redirect_pc", 64'(rpc), 64'(e.rpc));
        chk("ex_valid", 64'(exv), 64'(e.exv));
        chk("ex_tval", tval, e.tval);
      end
    end
    if (rst_n && updv && upd_ready) begin
      if (upd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_upd: got pc=0x%0h want no entry", upd_pc);
      end else begin
        upd_t u;
        u = upd_q.pop_front();
        chk("upd_pc", 64'(upd_pc), 64'(u.pc));
        chk("upd_target", 64'(upd_tgt), 64'(u.tgt));
        chk("upd_taken", 64'(upd_taken), 64'(u.taken));
        chk("upd_mispredict", 64'(upd_misp), 64'(u.misp));
        chk("upd_cf", 64'(upd_cf), 64'(u.cf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

  initial begin
    clear_ports();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_upd_valid", 64'(updv), 64'd0);
    chk("reset_mispredict", 64'(misp), 64'd0);
    chk("reset_result_valid", 64'(rv), 64'd0);
    chk("reset_ex_valid", 64'(exv), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(ready), 64'd1);
    upd_ready = 1'b1;

    // taken branch predicted NoCF
    next_slot();
    set_port(0, 1, 39'h1000, 39'h0, 39'h20, 1'b0, 1'b1, 3'd0, 39'h0);
    exp_res(2'b01, 39'h1004, 39'h0, 1'b1, 39'h1020, 1'b0, 64'h0);
    exp_upd(39'h1000, 39'h1020, 1'b1, 1'b1, 3'd1);

    // correctly predicted JALR with bit-0 clear, plus not-taken compressed branch
    next_slot();
    set_port(0, 2, 39'h3000, 39'h2001, 39'h4, 1'b0, 1'b0, 3'd3, 39'h2004);
    set_port(1, 1, 39'h3004, 39'h0, 39'h40, 1'b1, 1'b0, 3'd0, 39'h0);
    exp_res(2'b11, 39'h3004, 39'h3006, 1'b0, 39'h0, 1'b0, 64'h0);
    exp_upd(39'h3000, 39'h2004, 1'b1, 1'b0, 3'd3);
    exp_upd(39'h3004, 39'h3006, 1'b0, 1'b0, 3'd1);

    // predicted-taken branch not taken; younger JAL squashed
    next_slot();
    set_port(0, 1, 39'h4000, 39'h0, 39'h7F_FFFF_FFF8, 1'b0, 1'b0, 3'd1, 39'h0);
    set_port(1, 0, 39'h4004, 39'h0, 39'h100, 1'b0, 1'b0, 3'd2, 39'h0);
    exp_res(2'b01, 39'h4004, 39'h0, 1'b1, 39'h4004, 1'b0, 64'h0);
    exp_upd(39'h4000, 39'h4004, 1'b0, 1'b1, 3'd1);

    // odd JAL target on port 0 excepts and squashes port 1
    next_slot();
    set_port(0, 0, 39'h100, 39'h0, 39'h5, 1'b0, 1'b0, 3'd2, 39'h0);
    set_port(1, 0, 39'h200, 39'h0, 39'h8, 1'b0, 1'b0, 3'd2, 39'h0);
    exp_res(2'b00, 39'h0, 39'h0, 1'b0, 39'h0, 1'b1, 64'h100);

    // exception on port 1 with high pc: tval sign-extended
    next_slot();
    set_port(0, 0, 39'h500, 39'h0, 39'h10, 1'b1, 1'b0, 3'd2, 39'h0);
    set_port(1, 0, 39'h40_0000_0000, 39'h0, 39'h1, 1'b0, 1'b0, 3'd2, 39'h0);
    exp_res(2'b01, 39'h502, 39'h0, 1'b0, 39'h0, 1'b1, 64'hFFFF_FFC0_0000_0000);
    exp_upd(39'h500, 39'h510, 1'b1, 1'b0, 3'd2);

    // JALR predicted Return with wrong address keeps cf Return
    next_slot();
    set_port(0, 2, 39'h600, 39'h800, 39'h0, 1'b0, 1'b0, 3'd4, 39'h900);
    set_port(1, 1, 39'h604, 39'h0, 39'h8, 1'b0, 1'b1, 3'd0, 39'h0);
    exp_res(2'b01, 39'h604, 39'h0, 1'b1, 39'h800, 1'b0, 64'h0);
    exp_upd(39'h600, 39'h800, 1'b1, 1'b1, 3'd4);

    // JALR predicted NoCF mispredicts even with matching address
    next_slot();
    set_port(0, 2, 39'h700, 39'h710, 39'h0, 1'b0, 1'b0, 3'd0, 39'h710);
    exp_res(2'b01, 39'h704, 39'h0, 1'b1, 39'h710, 1'b0, 64'h0);
    exp_upd(39'h700, 39'h710, 1'b1, 1'b1, 3'd3);

    // target and next pc wrap modulo 2^VLEN
    next_slot();
    set_port(0, 0, 39'h7F_FFFF_FFF0, 39'h0, 39'h20, 1'b0, 1'b0, 3'd2, 39'h0);
    exp_res(2'b01, 39'h7F_FFFF_FFF4, 39'h0, 1'b0, 39'h0, 1'b0, 64'h0);
    exp_upd(39'h7F_FFFF_FFF0, 39'h10, 1'b1, 1'b0, 3'd2);

    // flush masks registered outputs, queue still trains
    next_slot();
    set_port(0, 1, 39'h900, 39'h0, 39'h30, 1'b0, 1'b1, 3'd0, 39'h0);
    flush = 1'b1;
    exp_upd(39'h900, 39'h930, 1'b1, 1'b1, 3'd1);
    next_slot();
    @(negedge clk);
    chk("flush_mispredict", 64'(misp), 64'd0);
    chk("flush_result_valid", 64'(rv), 64'd0);

    // RVC=0 instance: target bit 1 set excepts; RVC=1 instance resolves normally
    next_slot();
    set_port(0, 0, 39'h100, 39'h0, 39'h6, 1'b0, 1'b0, 3'd2, 39'h0);
    valid_r0 = valid;
    exp_res(2'b01, 39'h104, 39'h0, 1'b0, 39'h0, 1'b0, 64'h0);
    exp_upd(39'h100, 39'h106, 1'b1, 1'b0, 3'd2);
    next_slot();
    @(negedge clk);
    chk("rvc0_ex_valid", 64'(r0_exv), 64'd1);
    chk("rvc0_ex_tval", r0_tval, 64'h100);
    chk("rvc0_mispredict", 64'(r0_misp), 64'd0);
    chk("rvc0_upd_valid", 64'(r0_updv), 64'd0);

    // queue full / ready_o back-pressure
    next_slot();
    wait_drain();
    #1 upd_ready = 1'b0;
    next_slot();
    set_port(0, 0, 39'h1100, 39'h0, 39'h40, 1'b0, 1'b0, 3'd2, 39'h0);
    set_port(1, 0, 39'h1104, 39'h0, 39'h80, 1'b1, 1'b0, 3'd2, 39'h0);
    exp_res(2'b11, 39'h1104, 39'h1106, 1'b0, 39'h0, 1'b0, 64'h0);
    exp_upd(39'h1100, 39'h1140, 1'b1, 1'b0, 3'd2);
    exp_upd(39'h1104, 39'h1184, 1'b1, 1'b0, 3'd2);
    next_slot();
    set_port(0, 1, 39'h1200, 39'h0, 39'h10, 1'b0, 1'b1, 3'd1, 39'h0);
    set_port(1, 1, 39'h1210, 39'h0, 39'h10, 1'b0, 1'b0, 3'd0, 39'h0);
    exp_res(2'b11, 39'h1204, 39'h1214, 1'b0, 39'h0, 1'b0, 64'h0);
    exp_upd(39'h1200, 39'h1210, 1'b1, 1'b0, 3'd1);
    exp_upd(39'h1210, 39'h1214, 1'b0, 1'b0, 3'd1);
    next_slot();
    @(negedge clk);
    chk("full_ready", 64'(ready), 64'd0);
    @(posedge clk); #1 upd_ready = 1'b1;
    @(posedge clk); #1 upd_ready = 1'b0;
    @(negedge clk);
    chk("one_free_ready", 64'(ready), 64'd0);
    @(posedge clk); #1 upd_ready = 1'b1;
    @(posedge clk); #1 upd_ready = 1'b0;
    @(negedge clk);
    chk("two_free_ready", 64'(ready), 64'd1);
    @(posedge clk); #1 upd_ready = 1'b1;
    wait_drain();

    // asynchronous reset with 3 entries queued and a group in flight
    #1 upd_ready = 1'b0;
    next_slot();
    set_port(0, 0, 39'h2100, 39'h0, 39'h4, 1'b0, 1'b0, 3'd2, 39'h0);
    set_port(1, 0, 39'h2104, 39'h0, 39'h8, 1'b0, 1'b0, 3'd2, 39'h0);
    exp_res(2'b11, 39'h2104, 39'h2108, 1'b0, 39'h0, 1'b0, 64'h0);
    next_slot();
    set_port(0, 1, 39'h2200, 39'h0, 39'h10, 1'b0, 1'b1, 3'd0, 39'h0);
    exp_res(2'b01, 39'h2204, 39'h0, 1'b1, 39'h2210, 1'b0, 64'h0);
    next_slot();
    @(negedge clk);
    chk("three_entries_ready", 64'(ready), 64'd0);
    chk("three_entries_upd_valid", 64'(updv), 64'd1);
    @(posedge clk); #1;
    set_port(0, 0, 39'h2300, 39'h0, 39'h4, 1'b0, 1'b0, 3'd2, 39'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_upd_valid", 64'(updv), 64'd0);
    chk("async_rst_mispredict", 64'(misp), 64'd0);
    chk("async_rst_result_valid", 64'(rv), 64'd0);
    clear_ports();
    upd_q.delete();
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready), 64'd1);
    chk("post_rst_upd_valid", 64'(updv), 64'd0);

    upd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("results_outstanding", 64'(res_q.size()), 64'd0);
    chk("upd_outstanding", 64'(upd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
